// File: rtl/pgm_pkg.sv
// Shared definitions for the packet-generator session controller:
// control-packet field positions, op codes, register map and FSM states.
package pgm_pkg;

    localparam int CW = 134;

    localparam logic [7:0] LMID = 8'd60;
    localparam logic [7:0] NMID = 8'd61;

    // Control-packet field positions
    localparam int HDR_MSB  = 133;
    localparam int HDR_LSB  = 132;
    localparam int RESP_MSB = 127;
    localparam int RESP_LSB = 124;
    localparam int OP_MSB   = 126;
    localparam int OP_LSB   = 124;
    localparam int MID_MSB  = 103;
    localparam int MID_LSB  = 96;
    localparam int ADDR_MSB = 95;
    localparam int ADDR_LSB = 64;
    localparam int DATA_MSB = 31;
    localparam int DATA_LSB = 0;

    localparam logic [1:0] HDR_FIRST = 2'b01;
    localparam logic [1:0] HDR_LAST  = 2'b10;

    localparam logic [2:0] OP_WR    = 3'b010;
    localparam logic [2:0] OP_RD    = 3'b001;
    localparam logic [3:0] RESP_NIB = 4'b1011;

    // Register map
    localparam logic [31:0] REG_CTRL       = 32'h0;
    localparam logic [31:0] REG_PKT_TARGET = 32'h1;
    localparam logic [31:0] REG_CYC_LIMIT  = 32'h2;
    localparam logic [31:0] REG_STATUS     = 32'h3;
    localparam logic [31:0] REG_PKT_CNT    = 32'h4;
    localparam logic [31:0] REG_CYC_CNT    = 32'h5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2,
        ST_DONE = 2'd3
    } pgm_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pgm_cfg_if.sv
// Control-stream front end: decodes packets addressed to this module, holds
// the configuration registers, answers reads and forwards every word one cycle later.
module pgm_cfg_if
    import pgm_pkg::*;
#(
    parameter logic [7:0] MID = LMID
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] cin_data,
    input  logic          cin_data_wr,
    input  logic          cin_ready,
    output logic [CW-1:0] cout_data,
    output logic          cout_data_wr,
    input  logic [1:0]    state,
    input  logic          ram_loaded,
    input  logic          start_err,
    input  logic [31:0]   pkt_cnt,
    input  logic [31:0]   cyc_cnt,
    output logic          start_stb,
    output logic          stop_stb,
    output logic          clear_stb,
    output logic          bypass,
    output logic [31:0]   pkt_target,
    output logic [31:0]   cyc_limit
);

    logic          accept;
    logic          hit;
    logic          is_wr;
    logic          is_rd;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [CW-1:0] fwd_word;

    logic [CW-1:0] cout_data_reg;
    logic          cout_data_wr_reg;
    logic          start_stb_reg;
    logic          stop_stb_reg;
    logic          clear_stb_reg;
    logic          bypass_reg;
    logic [31:0]   pkt_target_reg;
    logic [31:0]   cyc_limit_reg;

    assign accept = cin_data_wr && cin_ready;
    assign hit    = accept
                 && (cin_data[HDR_MSB:HDR_LSB] == HDR_FIRST)
                 && (cin_data[MID_MSB:MID_LSB] == MID);
    assign is_wr  = hit && (cin_data[OP_MSB:OP_LSB] == OP_WR);
    assign is_rd  = hit && (cin_data[OP_MSB:OP_LSB] == OP_RD);
    assign addr   = cin_data[ADDR_MSB:ADDR_LSB];
    assign wdata  = cin_data[DATA_MSB:DATA_LSB];

    always_comb begin
        rdata = 32'hFFFF_FFFF;
        case (addr)
            REG_CTRL:       rdata = 32'h0;
            REG_PKT_TARGET: rdata = pkt_target_reg;
            REG_CYC_LIMIT:  rdata = cyc_limit_reg;
            REG_STATUS:     rdata = {28'h0, start_err, ram_loaded, state};
            REG_PKT_CNT:    rdata = pkt_cnt;
            REG_CYC_CNT:    rdata = cyc_cnt;
            default:        rdata = 32'hFFFF_FFFF;
        endcase
    end

    // Read responses keep every bit except the response nibble and the data field.
    always_comb begin
        fwd_word = cin_data;
        if (is_rd) begin
            fwd_word[RESP_MSB:RESP_LSB] = RESP_NIB;
            fwd_word[DATA_MSB:DATA_LSB] = rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout_data_reg    <= '0;
            cout_data_wr_reg <= 1'b0;
            start_stb_reg    <= 1'b0;
            stop_stb_reg     <= 1'b0;
            clear_stb_reg    <= 1'b0;
            bypass_reg       <= 1'b0;
            pkt_target_reg   <= '0;
            cyc_limit_reg    <= '0;
        end else begin
            cout_data_wr_reg <= accept;
            if (accept) begin
                cout_data_reg <= fwd_word;
            end
            start_stb_reg <= 1'b0;
            stop_stb_reg  <= 1'b0;
            clear_stb_reg <= 1'b0;
            if (is_wr) begin
                case (addr)
                    REG_CTRL: begin
                        start_stb_reg <= wdata[0];
                        stop_stb_reg  <= wdata[1];
                        bypass_reg    <= wdata[2];
                        clear_stb_reg <= wdata[3];
                    end
                    REG_PKT_TARGET: pkt_target_reg <= wdata;
                    REG_CYC_LIMIT:  cyc_limit_reg  <= wdata;
                    default: ;
                endcase
            end
        end
    end

    assign cout_data    = cout_data_reg;
    assign cout_data_wr = cout_data_wr_reg;
    assign start_stb    = start_stb_reg;
    assign stop_stb     = stop_stb_reg;
    assign clear_stb    = clear_stb_reg;
    assign bypass       = bypass_reg;
    assign pkt_target   = pkt_target_reg;
    assign cyc_limit    = cyc_limit_reg;

endmodule

// File: rtl/pgm_ctrl.sv
// Packet-generator session controller: run FSM, packet/cycle counters and
// generator flags, with configuration through pgm_cfg_if on the control stream.
module pgm_ctrl
    import pgm_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ram_loaded,
    input  logic          pkt_sent,
    output logic          pgm_bypass_flag,
    output logic          pgm_sent_start_flag,
    output logic          pgm_sent_finish_flag,
    output logic          run_done,
    input  logic [CW-1:0] cin_data,
    input  logic          cin_data_wr,
    output logic          cout_ready,
    output logic [CW-1:0] cout_data,
    output logic          cout_data_wr,
    input  logic          cin_ready
);

    pgm_state_t  state_reg;
    pgm_state_t  state_next;
    logic [31:0] pkt_cnt_reg;
    logic [31:0] pkt_cnt_next;
    logic [31:0] cyc_cnt_reg;
    logic [31:0] cyc_cnt_next;
    logic        start_err_reg;
    logic        start_err_next;

    logic        start_stb;
    logic        stop_stb;
    logic        clear_stb;
    logic        bypass;
    logic [31:0] pkt_target;
    logic [31:0] cyc_limit;

    logic [32:0] pkt_sum;
    logic        pkt_hit;
    logic        cyc_hit;
    logic        finish_cond;

    pgm_cfg_if #(
        .MID(LMID)
    ) u_cfg (
        .clk         (clk),
        .rst_n       (rst_n),
        .cin_data    (cin_data),
        .cin_data_wr (cin_data_wr),
        .cin_ready   (cin_ready),
        .cout_data   (cout_data),
        .cout_data_wr(cout_data_wr),
        .state       (state_reg),
        .ram_loaded  (ram_loaded),
        .start_err   (start_err_reg),
        .pkt_cnt     (pkt_cnt_reg),
        .cyc_cnt     (cyc_cnt_reg),
        .start_stb   (start_stb),
        .stop_stb    (stop_stb),
        .clear_stb   (clear_stb),
        .bypass      (bypass),
        .pkt_target  (pkt_target),
        .cyc_limit   (cyc_limit)
    );

    // Look ahead by one packet so the finish flag covers the whole final packet.
    assign pkt_sum     = {1'b0, pkt_cnt_reg} + 33'(pkt_sent);
    assign pkt_hit     = (pkt_target != '0) && (pkt_sum >= ({1'b0, pkt_target} - 33'd1));
    assign cyc_hit     = (cyc_limit != '0) && (cyc_cnt_reg >= cyc_limit);
    assign finish_cond = stop_stb || pkt_hit || cyc_hit;

    always_comb begin
        state_next     = state_reg;
        pkt_cnt_next   = pkt_cnt_reg;
        cyc_cnt_next   = cyc_cnt_reg;
        start_err_next = start_err_reg;
        if (clear_stb) begin
            start_err_next = 1'b0;
        end
        case (state_reg)
            ST_IDLE: begin
                if (start_stb && !stop_stb) begin
                    if (ram_loaded) begin
                        pkt_cnt_next = '0;
                        cyc_cnt_next = '0;
                        state_next   = ST_RUN;
                    end else begin
                        start_err_next = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cyc_cnt_next = sat_inc(cyc_cnt_reg);
                if (pkt_sent) begin
                    pkt_cnt_next = sat_inc(pkt_cnt_reg);
                end
                if (finish_cond) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                if (pkt_sent) begin
                    pkt_cnt_next = sat_inc(pkt_cnt_reg);
                    state_next   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (clear_stb) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            pkt_cnt_reg   <= '0;
            cyc_cnt_reg   <= '0;
            start_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pkt_cnt_reg   <= pkt_cnt_next;
            cyc_cnt_reg   <= cyc_cnt_next;
            start_err_reg <= start_err_next;
        end
    end

    assign pgm_bypass_flag      = bypass && (state_reg == ST_IDLE);
    assign pgm_sent_start_flag  = (state_reg == ST_RUN) || (state_reg == ST_FIN);
    assign pgm_sent_finish_flag = (state_reg == ST_FIN);
    assign run_done             = (state_reg == ST_DONE);
    assign cout_ready           = cin_ready;

endmodule
